edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter: NUM_CH, default 4, number of monitored input channels.
REQ-002 Parameter: TS_W, default 16, timestamp width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 a_i  input  NUM_CH  level inputs to monitor; bit c is channel c, already synchronous to clk.
REQ-006 mode_i  input  2*NUM_CH  per-channel detect mode: 00 off, 01 rising, 10 falling, 11 both.
REQ-007 clear_ovf_i  input  1  single-cycle pulse that clears all overflow flags.
REQ-008 event_valid_o  output  1  event word valid.
REQ-009 event_ready_i  input  1  consumer accepts the event when high together with event_valid_o.
REQ-010 event_ch_o  output  $clog2(NUM_CH)  channel index of the presented event.
REQ-011 event_rise_o  output  1  1 = rising edge, 0 = falling edge.
REQ-012 event_ts_o  output  TS_W  timestamp of the edge.
REQ-013 overflow_o  output  NUM_CH  sticky per-channel flag: an edge was dropped.

Function
REQ-014 Free-running TS_W-bit counter; increments every cycle; wraps from all-ones to 0.
REQ-015 Sequencing FSM: INIT -> RUN. INIT lasts exactly one cycle after reset release: a_i is sampled into the prior-value register a_q and no edge is detected.
REQ-016 In RUN, channel c detects an edge at posedge N when a_i[c] != a_q[c] and the edge direction is enabled by mode_i[c]. a_q is updated every cycle regardless of mode.
REQ-017 On detection at posedge N: pending[c] is set, the edge type is stored, and the timestamp counter value at posedge N is stored.
REQ-018 If a new edge is detected while pending[c] is set and not being cleared in the same cycle: the stored event is kept, the new edge is dropped, and overflow_o[c] is set.
REQ-019 If a new edge is detected in the same cycle that pending[c] is cleared by grant: the new edge becomes pending and no overflow is flagged.
REQ-020 Output FSM: EMPTY / FULL. In EMPTY, or in FULL with event_valid_o && event_ready_i, if any pending bit is set, a grant is issued: the output registers load the winner, pending[winner] is cleared, and the state becomes FULL. Otherwise the state becomes EMPTY.
REQ-021 Arbitration is round-robin. The search starts at last_grant+1 modulo NUM_CH. last_grant resets to NUM_CH-1, so channel 0 wins first.
REQ-022 While event_valid_o && !event_ready_i: event_ch_o, event_rise_o and event_ts_o hold stable, and no grant occurs.
REQ-023 Latency: an edge detected at posedge N on an idle block gives event_valid_o high after posedge N+1. Back-to-back accepted events sustain one event per cycle.
REQ-024 clear_ovf_i clears all overflow bits at the next posedge. A same-cycle overflow set takes priority over the clear.
REQ-025 Changing mode_i[c] to 00 suppresses new detection only. An already pending event is still delivered.

Reset
REQ-026 Reset asserted, including mid-operation, forces immediately:
- FSM to INIT and output FSM to EMPTY;
- event_valid_o=0, event_ch_o=0, event_rise_o=0, event_ts_o=0;
- overflow_o=0, pending=0, a_q=0;
- timestamp counter to 0 and last_grant to NUM_CH-1.
Any in-flight event is discarded.

Structure
REQ-027 A shared package edge_pkg holds NUM_CH and TS_W defaults, the mode enum (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the event struct (ch, rise, ts).
REQ-028 One sub-module, edge_chan, is instantiated NUM_CH times. It contains the per-channel a_q, detection, pending, type and timestamp storage, and overflow logic. Arbitration and output registers live in the top level.

Verification
REQ-029 Reset with a_i=4'b1111, release, hold a_i for 5 cycles -> no event_valid_o (INIT suppresses a false rising edge).
REQ-030 Mode 01 on ch2, ready=1, a_i[2] 0->1 sampled at posedge with counter=0x0010 -> one cycle later event_valid_o=1, ch=2, rise=1, ts=0x0010.
REQ-031 Mode 11 on all channels, a_i 0000->1111 in one cycle, ready=1 -> four consecutive events, ch 0,1,2,3, all rise=1, identical ts.
REQ-032 Ready=0, ch1 event held, toggle a_i[1] twice -> outputs stable, overflow_o[1]=1; pulse clear_ovf_i -> overflow_o=0.
REQ-033 Ch0 and ch3 toggling every cycle, ready=1 -> grants alternate 0,3,0,3 with no starvation.
REQ-034 Assert reset while event_valid_o=1 and pending bits are set -> outputs zero immediately; after release, no stale events appear.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge event arbiter and its per-channel detectors.
package edge_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned TS_W_DEF   = 16;
    localparam int unsigned CH_W_DEF   = $clog2(NUM_CH_DEF);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    typedef enum logic {
        SEQ_INIT,
        SEQ_RUN
    } seq_state_e;

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    typedef struct packed {
        logic [CH_W_DEF-1:0] ch;
        logic                rise;
        logic [TS_W_DEF-1:0] ts;
    } event_t;

endpackage

// File: rtl/edge_chan.sv
// One monitored channel: edge detection, single-entry event storage and sticky overflow.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned TS_W = TS_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            a,
    input  logic [1:0]      mode,
    input  logic            clear_ovf,
    input  logic            grant,
    input  logic [TS_W-1:0] ts,
    output logic            pending,
    output logic            rise,
    output logic [TS_W-1:0] ts_q,
    output logic            overflow
);

    logic  a_q;
    mode_e m;
    logic  rise_en;
    logic  fall_en;
    logic  detect;
    logic  drop;

    assign m       = mode_e'(mode);
    assign rise_en = (m == MODE_RISE) || (m == MODE_BOTH);
    assign fall_en = (m == MODE_FALL) || (m == MODE_BOTH);
    assign detect  = run && ((a && !a_q && rise_en) || (!a && a_q && fall_en));
    // A grant in the same cycle frees the slot, so only an un-granted pending entry drops.
    assign drop    = detect && pending && !grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= 1'b0;
            pending  <= 1'b0;
            rise     <= 1'b0;
            ts_q     <= '0;
            overflow <= 1'b0;
        end else begin
            a_q <= a;
            if (detect && !drop) begin
                pending <= 1'b1;
                rise    <= a;
                ts_q    <= ts;
            end else if (grant) begin
                pending <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Timestamped edge monitor: per-channel detectors feeding a round-robin arbiter and a one-deep output register.
module edge_event_arbiter
    import edge_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned TS_W   = TS_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         a_i,
    input  logic [2*NUM_CH-1:0]       mode_i,
    input  logic                      clear_ovf_i,
    output logic                      event_valid_o,
    input  logic                      event_ready_i,
    output logic [$clog2(NUM_CH)-1:0] event_ch_o,
    output logic                      event_rise_o,
    output logic [TS_W-1:0]           event_ts_o,
    output logic [NUM_CH-1:0]         overflow_o
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [TS_W-1:0]   ts_cnt;
    seq_state_e        seq;
    out_state_e        ost;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   win;
    logic [CH_W-1:0]   cand;
    logic              found;
    logic              can_grant;
    logic              do_grant;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] rise_vec;
    logic [NUM_CH-1:0] grant_vec;
    logic [TS_W-1:0]   ts_arr [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    // INIT spends one cycle loading the prior-value registers before detection is armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq <= SEQ_INIT;
        end else begin
            case (seq)
                SEQ_INIT: seq <= SEQ_RUN;
                default:  seq <= SEQ_RUN;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        edge_chan #(
            .TS_W(TS_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .run       (seq == SEQ_RUN),
            .a         (a_i[c]),
            .mode      (mode_i[2*c +: 2]),
            .clear_ovf (clear_ovf_i),
            .grant     (grant_vec[c]),
            .ts        (ts_cnt),
            .pending   (pending[c]),
            .rise      (rise_vec[c]),
            .ts_q      (ts_arr[c]),
            .overflow  (overflow_o[c])
        );
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((32'(last_grant) + 32'd1 + i) % NUM_CH);
            if (!found && pending[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign event_valid_o = (ost == OUT_FULL);
    assign can_grant     = (ost == OUT_EMPTY) || (event_valid_o && event_ready_i);
    assign do_grant      = can_grant && found;

    always_comb begin
        grant_vec = '0;
        if (do_grant) begin
            grant_vec[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ost          <= OUT_EMPTY;
            event_ch_o   <= '0;
            event_rise_o <= 1'b0;
            event_ts_o   <= '0;
            last_grant   <= CH_W'(NUM_CH - 1);
        end else if (can_grant) begin
            if (found) begin
                ost          <= OUT_FULL;
                event_ch_o   <= win;
                event_rise_o <= rise_vec[win];
                event_ts_o   <= ts_arr[win];
                last_grant   <= win;
            end else begin
                ost <= OUT_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with hand-computed expected events.
module tb_edge_event_arbiter;
    import edge_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  a_i = 4'h0;
    logic [7:0]  mode_i = 8'h00;
    logic        clear_ovf_i = 1'b0;
    logic        event_valid_o;
    logic        event_ready_i = 1'b0;
    logic [1:0]  event_ch_o;
    logic        event_rise_o;
    logic [15:0] event_ts_o;
    logic [3:0]  overflow_o;

    int total = 0;
    int bad = 0;
    int cycles = 0;
    int t = 0;
    event_t exp_ev;

    edge_event_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .a_i           (a_i),
        .mode_i        (mode_i),
        .clear_ovf_i   (clear_ovf_i),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_ch_o    (event_ch_o),
        .event_rise_o  (event_rise_o),
        .event_ts_o    (event_ts_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // cycles equals the timestamp counter value sampled at the next posedge.
    task automatic step();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cycles = 0;
    endtask

    task automatic check_event(input string tag, input event_t e);
        check({tag, "_valid"}, 32'(event_valid_o), 32'd1);
        check({tag, "_ch"}, 32'(event_ch_o), 32'(e.ch));
        check({tag, "_rise"}, 32'(event_rise_o), 32'(e.rise));
        check({tag, "_ts"}, 32'(event_ts_o), 32'(e.ts));
    endtask

    initial begin
        // Reset values
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 32'(event_valid_o), 32'd0);
        check("rst_ch", 32'(event_ch_o), 32'd0);
        check("rst_rise", 32'(event_rise_o), 32'd0);
        check("rst_ts", 32'(event_ts_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);

        // High inputs across reset release must not look like rising edges
        a_i = 4'hF; mode_i = 8'hFF; event_ready_i = 1'b1;
        do_reset();
        repeat (5) begin
            step();
            check("init_valid", 32'(event_valid_o), 32'd0);
        end

        // Single rising edge on ch2 at timestamp 0x10
        a_i = 4'h0; mode_i = 8'h10; event_ready_i = 1'b1;
        do_reset();
        repeat (16) step();
        a_i = 4'b0100;
        step();
        check("lat_valid", 32'(event_valid_o), 32'd0);
        step();
        exp_ev = '{ch: 2'd2, rise: 1'b1, ts: 16'h0010};
        check_event("single", exp_ev);
        step();
        check("single_done", 32'(event_valid_o), 32'd0);

        // Four simultaneous edges drain in channel order with one timestamp
        a_i = 4'h0; mode_i = 8'hFF; event_ready_i = 1'b1;
        do_reset();
        repeat (3) step();
        a_i = 4'hF; t = cycles;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            exp_ev = '{ch: 2'(i), rise: 1'b1, ts: 16'(t)};
            check_event("burst", exp_ev);
        end
        step();
        check("burst_done", 32'(event_valid_o), 32'd0);
        check("burst_ovf", 32'(overflow_o), 32'd0);

        // Backpressure: held outputs, overflow, clear priority, kept event
        a_i = 4'h0; mode_i = 8'hFF; event_ready_i = 1'b0;
        do_reset();
        repeat (2) step();
        a_i = 4'b0010; t = cycles;
        step();
        step();
        exp_ev = '{ch: 2'd1, rise: 1'b1, ts: 16'(t)};
        check_event("hold0", exp_ev);
        a_i = 4'b0000;
        step();
        a_i = 4'b0010;
        step();
        check_event("hold1", exp_ev);
        check("ovf_set", 32'(overflow_o), 32'h2);
        clear_ovf_i = 1'b1; a_i = 4'b0000;
        step();
        clear_ovf_i = 1'b0;
        check("ovf_prio", 32'(overflow_o), 32'h2);
        clear_ovf_i = 1'b1;
        step();
        clear_ovf_i = 1'b0;
        check("ovf_clr", 32'(overflow_o), 32'h0);
        check_event("hold2", exp_ev);
        event_ready_i = 1'b1;
        step();
        exp_ev = '{ch: 2'd1, rise: 1'b0, ts: 16'(t + 2)};
        check_event("kept", exp_ev);
        step();
        check("kept_done", 32'(event_valid_o), 32'd0);

        // Ch0 and ch3 toggling every cycle alternate grants
        a_i = 4'h0; mode_i = 8'hC3; event_ready_i = 1'b1;
        do_reset();
        repeat (2) step();
        a_i ^= 4'b1001;
        step();
        for (int i = 0; i < 6; i++) begin
            a_i ^= 4'b1001;
            step();
            check("rr_valid", 32'(event_valid_o), 32'd1);
            check("rr_ch", 32'(event_ch_o), (i % 2 == 0) ? 32'd0 : 32'd3);
        end

        // Reset mid-operation discards everything
        a_i = 4'h0; mode_i = 8'hFF; event_ready_i = 1'b0;
        do_reset();
        repeat (2) step();
        a_i = 4'b1100;
        step();
        step();
        check("mid_valid_pre", 32'(event_valid_o), 32'd1);
        check("mid_ch_pre", 32'(event_ch_o), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_valid", 32'(event_valid_o), 32'd0);
        check("mid_ch", 32'(event_ch_o), 32'd0);
        check("mid_rise", 32'(event_rise_o), 32'd0);
        check("mid_ts", 32'(event_ts_o), 32'd0);
        check("mid_ovf", 32'(overflow_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycles = 0;
        event_ready_i = 1'b1;
        repeat (6) begin
            step();
            check("mid_stale", 32'(event_valid_o), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
